// File: rtl/root_solver.sv
// Recovers B from the forward datapath XOUT = A - 3*B - TEMP (mod 256).
// B = (A - XOUT - TEMP) * inverse(3), computed as an 8-cycle serial shift-add.
module root_solver #(
  parameter logic [7:0] TEMP = 8'd21
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_a,
  input  logic [7:0] i_xout,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_b,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  // 171 is the multiplicative inverse of 3 modulo 256.
  localparam logic [7:0] INV3 = 8'hAB;

  state_t     r_state;
  logic [7:0] r_d;
  logic [7:0] r_acc;
  logic [7:0] r_b;
  logic [2:0] r_cnt;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       r_busy;

  logic [7:0] w_term;
  logic [7:0] w_sum;

  assign w_term = INV3[r_cnt] ? (r_d << r_cnt) : 8'd0;
  assign w_sum  = r_acc + w_term;

  // The handshake outputs are registered alongside the state so they never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_d         <= 8'd0;
      r_acc       <= 8'd0;
      r_b         <= 8'd0;
      r_cnt       <= 3'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_d        <= i_a - i_xout - TEMP;
            r_acc      <= 8'd0;
            r_cnt      <= 3'd0;
            r_state    <= S_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MUL: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_b         <= w_sum;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_b         = r_b;

endmodule

// File: tb/tb_root_solver.sv
// Self-checking bench for root_solver: directed latency, wrap, backpressure and
// reset-abort cases, then randomized traffic against a brute-force inverse model.
module tb_root_solver;

  localparam logic [7:0] TEMP = 8'd21;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] x;
  } req_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] a;
  logic [7:0] xout;
  logic       outValid;
  logic       outReady;
  logic [7:0] b;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  req_t pending[$];

  always #5 clk = ~clk;

  root_solver #(.TEMP(TEMP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (inValid),
    .o_in_ready (inReady),
    .i_a        (a),
    .i_xout     (xout),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_b        (b),
    .o_busy     (busy)
  );

  // Reference: search for the unique B that makes the forward equation hold.
  function automatic logic [7:0] refInverse(input logic [7:0] ra, input logic [7:0] rx);
    for (int k = 0; k < 256; k++) begin
      if (8'(ra - 8'(3 * k) - TEMP) == rx) return 8'(k);
    end
    return 8'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the following rising edge.
  task automatic applyStimulus(input logic [7:0] ra, input logic [7:0] rx);
    a       = ra;
    xout    = rx;
    inValid = 1'b1;
    checkOutput("readyBeforeAccept", inReady, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    a       = 8'($urandom);
    xout    = 8'($urandom);
    checkOutput("busyAfterAccept", busy, 1);
  endtask

  // Walks the eight MUL edges while injecting ignored requests and input noise.
  task automatic checkLatency(input logic [7:0] expB);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      inValid = 1'($urandom_range(0, 1));
      a       = 8'($urandom);
      xout    = 8'($urandom);
      @(posedge clk);
      #1;
      if (k < 8) begin
        checkOutput("outValidEarly", outValid, 0);
      end else begin
        checkOutput("outValidAt8", outValid, 1);
        checkOutput("resultB", b, expB);
      end
      checkOutput("inReadyWhileBusy", inReady, 0);
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] expB);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("outValidAfterHs", outValid, 0);
    checkOutput("inReadyAfterHs", inReady, 1);
    checkOutput("busyAfterHs", busy, 0);
    checkOutput("bRetained", b, expB);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  initial begin
    bit sawValid;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    a        = 8'd0;
    xout     = 8'd0;
    #12;
    checkOutput("rstInReady", inReady, 1);
    checkOutput("rstOutValid", outValid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstB", b, 0);

    // First accept on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'd100, 8'd49);
    checkLatency(8'd10);
    handshake(8'd10);

    applyStimulus(8'd5, 8'd152);
    checkLatency(8'd200);
    handshake(8'd200);

    applyStimulus(8'd21, 8'd0);
    checkLatency(8'd0);
    handshake(8'd0);

    // Backpressure: result must hold while the consumer stalls.
    applyStimulus(8'd100, 8'd49);
    checkLatency(8'd10);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      inValid = 1'($urandom_range(0, 1));
      a       = 8'($urandom);
      xout    = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("bpOutValid", outValid, 1);
      checkOutput("bpB", b, 10);
      checkOutput("bpInReady", inReady, 0);
    end
    @(negedge clk);
    inValid = 1'b0;
    handshake(8'd10);

    // Abort in the 4th MUL cycle.
    applyStimulus(8'd100, 8'd49);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortInReady", inReady, 1);
    checkOutput("abortOutValid", outValid, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortB", b, 0);
    @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("noResultAfterAbort", sawValid, 0);
    applyStimulus(8'd21, 8'd0);
    checkLatency(8'd0);
    handshake(8'd0);

    // Randomized traffic: producer and consumer run independently.
    fork
      begin
        req_t r;
        bit   accepted;
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          r.a      = 8'($urandom);
          r.x      = 8'($urandom);
          a        = r.a;
          xout     = r.x;
          inValid  = 1'b1;
          accepted = 1'b0;
          for (int t = 0; t < 60 && !accepted; t++) begin
            accepted = inReady;
            @(posedge clk);
            if (accepted) pending.push_back(r);
            @(negedge clk);
          end
          checkOutput("acceptWithinBudget", accepted, 1);
          inValid = 1'b0;
          a       = 8'($urandom);
          xout    = 8'($urandom);
        end
      end
      begin
        int   got;
        int   cyc;
        req_t e;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          outReady = ($urandom_range(0, 3) != 0);
          if (outValid && outReady) begin
            checkOutput("resultHasRequest", pending.size() > 0, 1);
            if (pending.size() > 0) begin
              e = pending.pop_front();
              checkOutput("randResult", b, refInverse(e.a, e.x));
              checkOutput("randForward", 8'(e.a - 8'(3 * b) - TEMP), e.x);
            end
            got++;
          end
        end
        outReady = 1'b0;
        checkOutput("resultCount", got, 1000);
      end
    join
    checkOutput("noLeftoverRequests", pending.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
